// File: rtl/hqm_list_sel_mem_rf_pg_ctl.sv
// List-select register-file wrapper with built-in power-gate sequencing.
// Zero-sweeps the array after reset and (optionally) after every wake.
module hqm_list_sel_mem_rf_pg_ctl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WIDTH        = 18,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned WAKE_CYC     = 4,
  parameter int unsigned INIT_ON_WAKE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_v,
  output logic             ready,
  input  logic             pwr_req_off,
  output logic             pgcb_isol_en,
  output logic             pwr_enable_b_out,
  output logic             addr_err
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ON,
    S_ISOL,
    S_OFF,
    S_WAKE
  } state_e;

  localparam int unsigned WCW =
    (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [AW-1:0]  PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(WAKE_CYC - 1);
  localparam logic [AW:0]    DEPTH_X   = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             ready_q, ready_d;
  logic             isol_q, isol_d;
  logic             pwroff_q, pwroff_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rdata_v_q, rdata_v_d;
  logic             addr_err_q, addr_err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic waddr_ok;
  logic raddr_ok;
  logic wr_acc;
  logic rd_acc;
  logic wr_ok;
  logic bypass;

  assign waddr_ok = {1'b0, waddr} < DEPTH_X;
  assign raddr_ok = {1'b0, raddr} < DEPTH_X;
  assign wr_acc   = ready_q & we;
  assign rd_acc   = ready_q & re;
  assign wr_ok    = wr_acc & waddr_ok;
  assign bypass   = wr_ok & (waddr == raddr);

  // Power/sweep sequencer: next state, sweep pointer, wake counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (pwr_req_off) state_d = S_ISOL;
      end
      S_ISOL: begin
        state_d = S_OFF;
      end
      S_OFF: begin
        if (!pwr_req_off) begin
          state_d = S_WAKE;
          wcnt_d  = '0;
        end
      end
      S_WAKE: begin
        wcnt_d = wcnt_q + WCW'(1);
        if (wcnt_q == WCNT_LAST) begin
          if (INIT_ON_WAKE != 0) state_d = S_INIT;
          else                   state_d = S_ON;
        end
      end
      default: begin
        state_d = S_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    ready_d  = (state_d == S_ON);
    isol_d   = (state_d == S_ISOL) ||
               (state_d == S_OFF)  ||
               (state_d == S_WAKE);
    pwroff_d = (state_d == S_OFF);
  end

  // Read port: bypass, out-of-range zero, hold when idle.
  always_comb begin
    rdata_d    = rdata_q;
    rdata_v_d  = rd_acc;
    addr_err_d = (wr_acc & ~waddr_ok) | (rd_acc & ~raddr_ok);
    if (rd_acc) begin
      if (!raddr_ok)   rdata_d = '0;
      else if (bypass) rdata_d = wdata;
      else             rdata_d = mem_q[raddr];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      ready_q    <= 1'b0;
      isol_q     <= 1'b0;
      pwroff_q   <= 1'b0;
      rdata_q    <= '0;
      rdata_v_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      ready_q    <= ready_d;
      isol_q     <= isol_d;
      pwroff_q   <= pwroff_d;
      rdata_q    <= rdata_d;
      rdata_v_q  <= rdata_v_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage: contents lost while off, zero sweep in INIT, client writes in ON.
  always_ff @(posedge clk) begin
    if (state_q == S_OFF) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 'x;
      end
    end else if (state_q == S_INIT) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata            = isol_q ? '0 : rdata_q;
  assign rdata_v          = rdata_v_q;
  assign ready            = ready_q;
  assign pgcb_isol_en     = isol_q;
  assign pwr_enable_b_out = pwroff_q;
  assign addr_err         = addr_err_q;

endmodule

// File: tb/tb_hqm_list_sel_mem_rf_pg_ctl.sv
// Directed bench for hqm_list_sel_mem_rf_pg_ctl.
// Three instances: D8/init-on-wake, D8/no-init, D6/init-on-wake.
module tb_hqm_list_sel_mem_rf_pg_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we, re, pwr_req_off;
  logic [2:0]  waddr, raddr;
  logic [17:0] wdata;

  logic [17:0] a_rd, b_rd, c_rd;
  logic        a_v, b_v, c_v;
  logic        a_rdy, b_rdy, c_rdy;
  logic        a_iso, b_iso, c_iso;
  logic        a_pwr, b_pwr, c_pwr;
  logic        a_err, b_err, c_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hqm_list_sel_mem_rf_pg_ctl #(
    .DEPTH(8), .WIDTH(18), .WAKE_CYC(4), .INIT_ON_WAKE(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr),
    .rdata(a_rd), .rdata_v(a_v), .ready(a_rdy),
    .pwr_req_off(pwr_req_off),
    .pgcb_isol_en(a_iso), .pwr_enable_b_out(a_pwr),
    .addr_err(a_err)
  );

  hqm_list_sel_mem_rf_pg_ctl #(
    .DEPTH(8), .WIDTH(18), .WAKE_CYC(4), .INIT_ON_WAKE(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr),
    .rdata(b_rd), .rdata_v(b_v), .ready(b_rdy),
    .pwr_req_off(pwr_req_off),
    .pgcb_isol_en(b_iso), .pwr_enable_b_out(b_pwr),
    .addr_err(b_err)
  );

  hqm_list_sel_mem_rf_pg_ctl #(
    .DEPTH(6), .WIDTH(18), .WAKE_CYC(4), .INIT_ON_WAKE(1)
  ) u_c (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr),
    .rdata(c_rd), .rdata_v(c_v), .ready(c_rdy),
    .pwr_req_off(pwr_req_off),
    .pgcb_isol_en(c_iso), .pwr_enable_b_out(c_pwr),
    .addr_err(c_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [17:0] wdata;
    logic        re;
    logic [2:0]  raddr;
    logic [17:0] exp_rd;
    logic        exp_v;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  // Steps up to maxc cycles; records the first cycle each instance is
  // ready, its rdata at that moment, and any rdata_v seen after a cycle
  // in which it was not ready.
  task automatic run_until_ready(input int maxc,
                                 output int ta, output int tb2,
                                 output int tc,
                                 output logic [17:0] ra,
                                 output logic [17:0] rb,
                                 output logic [17:0] rc,
                                 output int bad);
    logic pa, pb, pc;
    ta = -1; tb2 = -1; tc = -1; bad = 0;
    ra = '1; rb = '1; rc = '1;
    for (int k = 1; k <= maxc; k++) begin
      pa = a_rdy; pb = b_rdy; pc = c_rdy;
      step();
      if (!pa && a_v) bad++;
      if (!pb && b_v) bad++;
      if (!pc && c_v) bad++;
      if (a_rdy && ta < 0) begin ta = k; ra = a_rd; end
      if (b_rdy && tb2 < 0) begin tb2 = k; rb = b_rd; end
      if (c_rdy && tc < 0) begin tc = k; rc = c_rd; end
    end
  endtask

  logic [17:0] cexp [6];
  int ta, tb2, tc, bad;
  logic [17:0] ra, rb, rc;

  initial begin
    idle();
    pwr_req_off = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;

    // Reset values
    step(); step();
    chk("rst_a_rdy", a_rdy, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_a_v", a_v, 0);
    chk("rst_a_iso", a_iso, 0);
    chk("rst_a_pwr", a_pwr, 0);
    chk("rst_a_err", a_err, 0);

    // Reset to ready
    rst = 1'b0;
    run_until_ready(20, ta, tb2, tc, ra, rb, rc, bad);
    chk("boot_a_cyc", ta, 8);
    chk("boot_b_cyc", tb2, 8);
    chk("boot_c_cyc", tc, 6);
    chk("boot_nov", bad, 0);

    // Main read/write table
    for (int i = 0; i < 8; i++)
      vt.push_back('{1'b0, 3'd0, 18'd0, 1'b1, 3'(i),
                     18'd0, 1'b1, 1'b0});
    vt.push_back('{1'b1, 3'd3, 18'h2A5A5, 1'b0, 3'd0,
                   18'd0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'd0, 18'd0, 1'b1, 3'd3,
                   18'h2A5A5, 1'b1, 1'b0});
    vt.push_back('{1'b1, 3'd5, 18'h3FFFF, 1'b1, 3'd5,
                   18'h3FFFF, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'd0, 18'd0, 1'b1, 3'd5,
                   18'h3FFFF, 1'b1, 1'b0});
    vt.push_back('{1'b1, 3'd2, 18'h01234, 1'b1, 3'd3,
                   18'h2A5A5, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'd0, 18'd0, 1'b1, 3'd2,
                   18'h01234, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'd0, 18'd0, 1'b0, 3'd0,
                   18'h01234, 1'b0, 1'b0});

    foreach (vt[i]) begin
      we = vt[i].we; waddr = vt[i].waddr; wdata = vt[i].wdata;
      re = vt[i].re; raddr = vt[i].raddr;
      step();
      chk($sformatf("vec%0d_a_rd", i), a_rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_a_v", i), a_v, vt[i].exp_v);
      chk($sformatf("vec%0d_a_err", i), a_err, vt[i].exp_err);
      chk($sformatf("vec%0d_b_rd", i), b_rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_b_v", i), b_v, vt[i].exp_v);
    end

    // Out-of-range on DEPTH=6
    cexp = '{18'd0, 18'd0, 18'h01234, 18'h2A5A5, 18'd0, 18'h3FFFF};
    we = 1'b1; waddr = 3'd7; wdata = 18'h3FFFF; re = 1'b0;
    step();
    chk("oor_wr_c_err", c_err, 1);
    chk("oor_wr_c_v", c_v, 0);
    chk("oor_wr_a_err", a_err, 0);
    idle();
    for (int i = 0; i < 6; i++) begin
      re = 1'b1; raddr = 3'(i);
      step();
      chk($sformatf("c_rd%0d", i), c_rd, cexp[i]);
      chk($sformatf("c_v%0d", i), c_v, 1);
      chk($sformatf("c_err%0d", i), c_err, 0);
    end
    re = 1'b1; raddr = 3'd6;
    step();
    chk("oor_rd_c_rd", c_rd, 0);
    chk("oor_rd_c_v", c_v, 1);
    chk("oor_rd_c_err", c_err, 1);
    idle();
    step();
    chk("oor_pulse_c_err", c_err, 0);

    // Power down with a read accepted in the request cycle
    re = 1'b1; raddr = 3'd2; pwr_req_off = 1'b1;
    step();
    chk("isol_a_iso", a_iso, 1);
    chk("isol_a_rdy", a_rdy, 0);
    chk("isol_a_pwr", a_pwr, 0);
    chk("isol_a_v", a_v, 1);
    chk("isol_a_clamp", a_rd, 0);
    re = 1'b0;
    step();
    chk("off_a_pwr", a_pwr, 1);
    chk("off_a_iso", a_iso, 1);
    chk("off_c_pwr", c_pwr, 1);
    re = 1'b1; raddr = 3'd2;
    step();
    chk("off_a_nov", a_v, 0);
    chk("off_b_nov", b_v, 0);

    // Wake with requests held on the whole time
    pwr_req_off = 1'b0;
    run_until_ready(30, ta, tb2, tc, ra, rb, rc, bad);
    chk("wake_a_cyc", ta, 13);
    chk("wake_b_cyc", tb2, 5);
    chk("wake_c_cyc", tc, 11);
    chk("wake_nov", bad, 0);
    chk("wake_a_held_rd", ra, 18'h01234);
    chk("wake_b_held_rd", rb, 18'h01234);
    chk("wake_c_held_rd", rc, 18'h01234);
    chk("wake_a_iso", a_iso, 0);
    chk("wake_a_rd2", a_rd, 0);
    chk("wake_a_v", a_v, 1);
    chk("wake_c_rd2", c_rd, 0);

    // Reset mid-sweep
    re = 1'b1; we = 1'b1; raddr = 3'd4; waddr = 3'd4; wdata = 18'h00155;
    step();
    chk("pre_rst_a_rd", a_rd, 18'h00155);
    idle();
    rst = 1'b1;
    #1;
    chk("arst_a_rd", a_rd, 0);
    chk("arst_a_v", a_v, 0);
    chk("arst_a_rdy", a_rdy, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("sweep_a_rdy", a_rdy, 0);
    rst = 1'b1;
    #1;
    chk("msweep_a_rdy", a_rdy, 0);
    step();
    rst = 1'b0;
    run_until_ready(20, ta, tb2, tc, ra, rb, rc, bad);
    chk("resweep_a_cyc", ta, 8);
    chk("resweep_c_cyc", tc, 6);
    re = 1'b1; raddr = 3'd4;
    step();
    chk("resweep_a_rd4", a_rd, 0);
    chk("resweep_a_v", a_v, 1);
    idle();

    // Reset during WAKE
    pwr_req_off = 1'b1;
    step(); step(); step();
    pwr_req_off = 1'b0;
    step(); step();
    chk("inwake_a_iso", a_iso, 1);
    chk("inwake_a_pwr", a_pwr, 0);
    rst = 1'b1;
    #1;
    chk("wrst_a_iso", a_iso, 0);
    chk("wrst_b_iso", b_iso, 0);
    chk("wrst_a_pwr", a_pwr, 0);
    chk("wrst_a_rdy", a_rdy, 0);
    step();
    rst = 1'b0;
    run_until_ready(20, ta, tb2, tc, ra, rb, rc, bad);
    chk("wrst_a_cyc", ta, 8);
    chk("wrst_b_cyc", tb2, 8);
    chk("wrst_c_cyc", tc, 6);
    chk("wrst_nov", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
